// File: rtl/char_string_sequencer_pkg.sv
// char_string_sequencer_pkg: shared cell geometry, colour type and sequencer state codes
package char_string_sequencer_pkg;
  localparam int CELL_W_DEF = 8;
  localparam int CELL_H_DEF = 10;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  typedef logic [5:0] colour_t;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SCAN   = 2'd1;
  localparam state_t ST_DRAIN  = 2'd2;
  localparam state_t ST_FINISH = 2'd3;
endpackage

// File: rtl/char_string_sequencer_scan_counter.sv
// char_scan_counter: nested px/py/ci walk over character cells, px fastest
module char_scan_counter #(
  parameter int CELL_W = 8,
  parameter int CELL_H = 10,
  parameter int CNT_W  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             step_i,
  input  logic [CNT_W-1:0] count_i,
  output logic [7:0]       px_o,
  output logic [7:0]       py_o,
  output logic [CNT_W-1:0] ci_o,
  output logic             last_o
);
  logic [7:0] px_q, px_d, py_q, py_d;
  logic [CNT_W-1:0] ci_q, ci_d;
  logic px_end, py_end;
  assign px_end = px_q == 8'(CELL_W - 1);
  assign py_end = py_q == 8'(CELL_H - 1);
  assign last_o = px_end & py_end & (CNT_W'(ci_q + 1'b1) == count_i);
  assign px_o = px_q;
  assign py_o = py_q;
  assign ci_o = ci_q;
  // advance px, carry into py at the cell's right edge, carry into ci at its bottom
  always_comb begin
    px_d = clr_i ? '0 : step_i ? (px_end ? '0 : px_q + 8'd1) : px_q;
    py_d = clr_i ? '0 : (step_i & px_end) ? (py_end ? '0 : py_q + 8'd1) : py_q;
    ci_d = clr_i ? '0 : (step_i & px_end & py_end) ? CNT_W'(ci_q + 1'b1) : ci_q;
  end
  // counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      px_q <= '0;
      py_q <= '0;
      ci_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
      ci_q <= ci_d;
    end
  end
endmodule

// File: rtl/char_string_sequencer.sv
// char_string_sequencer: scans character cells through a glyph LUT and emits pixel plots
module char_string_sequencer
  import char_string_sequencer_pkg::*;
#(
  parameter int CELL_W = CELL_W_DEF,
  parameter int CELL_H = CELL_H_DEF,
  parameter int CNT_W  = 4
) (
  input  logic             clock_i,
  input  logic             resetn_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             clear_mode_i,
  input  logic [7:0]       origin_x_i,
  input  logic [7:0]       origin_y_i,
  input  logic [CNT_W-1:0] char_count_i,
  input  logic [5:0]       bg_colour_i,
  output logic [CNT_W-1:0] char_index_o,
  input  logic [7:0]       char_code_i,
  output logic [7:0]       glyph_code_o,
  output logic [7:0]       glyph_x_o,
  output logic [7:0]       glyph_y_o,
  input  logic             glyph_enable_i,
  input  logic [5:0]       glyph_colour_i,
  output logic             plot_o,
  output logic [7:0]       plot_x_o,
  output logic [7:0]       plot_y_o,
  output logic [5:0]       plot_colour_o,
  input  logic             plot_ready_i,
  output logic             busy_o,
  output logic             done_o
);
  state_t state_q, state_d;
  logic [7:0] ox_q, oy_q;
  logic [CNT_W-1:0] count_q;
  logic clear_q;
  colour_t bg_q;
  logic plot_q, done_q;
  logic [7:0] plot_x_q, plot_y_q;
  colour_t plot_colour_q;
  logic [7:0] px, py;
  logic [CNT_W-1:0] ci;
  logic last, accept, free, step;
  assign accept = (state_q == ST_IDLE) & start_i & !abort_i;
  assign free = !plot_q | plot_ready_i;
  assign step = (state_q == ST_SCAN) & free & !abort_i;
  char_scan_counter #(.CELL_W(CELL_W), .CELL_H(CELL_H), .CNT_W(CNT_W)) u_scan (
    .clk_i   (clock_i),
    .rst_ni  (resetn_i),
    .clr_i   (accept),
    .step_i  (step),
    .count_i (count_q),
    .px_o    (px),
    .py_o    (py),
    .ci_o    (ci),
    .last_o  (last)
  );
  assign char_index_o = ci;
  assign glyph_code_o = char_code_i;
  assign glyph_x_o = px;
  assign glyph_y_o = py;
  assign plot_o = plot_q;
  assign plot_x_o = plot_x_q;
  assign plot_y_o = plot_y_q;
  assign plot_colour_o = plot_colour_q;
  assign busy_o = state_q != ST_IDLE;
  assign done_o = done_q;
  // sequencing: abort beats everything, an empty string skips straight to FINISH
  always_comb begin
    state_d = abort_i ? ST_IDLE
            : accept ? (char_count_i == '0 ? ST_FINISH : ST_SCAN)
            : (step & last) ? ST_DRAIN
            : (state_q == ST_DRAIN & free) ? ST_FINISH
            : (state_q == ST_FINISH) ? ST_IDLE
            : state_q;
  end
  // state plus the job parameters captured when start is accepted
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      ox_q <= '0;
      oy_q <= '0;
      count_q <= '0;
      clear_q <= 1'b0;
      bg_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= (state_q == ST_FINISH) & !abort_i;
      if (accept) begin
        ox_q <= origin_x_i;
        oy_q <= origin_y_i;
        count_q <= char_count_i;
        clear_q <= clear_mode_i;
        bg_q <= bg_colour_i;
      end
    end
  end
  // output stage: loads on every step, holds a pending pixel until the arbiter takes it
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      plot_q <= 1'b0;
      plot_x_q <= '0;
      plot_y_q <= '0;
      plot_colour_q <= '0;
    end else if (abort_i) begin
      plot_q <= 1'b0;
    end else if (step) begin
      plot_q <= clear_q | glyph_enable_i;
      plot_x_q <= ox_q + 8'(int'(ci) * CELL_W) + px;
      plot_y_q <= oy_q + py;
      plot_colour_q <= clear_q ? bg_q : glyph_colour_i;
    end else if (plot_ready_i) begin
      plot_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_char_string_sequencer.sv
// tb_char_string_sequencer: randomized jobs checked against a pixel-list reference model
module tb_char_string_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0, abort_i = 1'b0, clear_mode_i = 1'b0, plot_ready_i = 1'b1;
  logic [7:0] origin_x_i = '0, origin_y_i = '0;
  logic [3:0] char_count_i = '0;
  logic [5:0] bg_colour_i = '0;
  logic [3:0] char_index_o;
  logic [7:0] char_code_i, glyph_code_o, glyph_x_o, glyph_y_o;
  logic glyph_enable_i;
  logic [5:0] glyph_colour_i;
  logic plot_o, busy_o, done_o;
  logic [7:0] plot_x_o, plot_y_o;
  logic [5:0] plot_colour_o;
  logic [7:0] str_mem [16];
  logic lut_mode = 1'b0;
  logic [21:0] exp_q [$];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  function automatic logic lut_en(input logic m, input logic [7:0] c, x, y);
    return m ? (x == 8'd2 && y == 8'd0) : ((int'(c) + int'(x) * 3 + int'(y) * 5) % 3 == 0);
  endfunction
  function automatic logic [5:0] lut_col(input logic [7:0] c, x, y);
    return 6'(c ^ (x << 3) ^ y);
  endfunction

  assign char_code_i = str_mem[char_index_o];
  assign glyph_enable_i = lut_en(lut_mode, glyph_code_o, glyph_x_o, glyph_y_o);
  assign glyph_colour_i = lut_col(glyph_code_o, glyph_x_o, glyph_y_o);

  char_string_sequencer dut (
    .clock_i(clk), .resetn_i(rst_n), .start_i(start_i), .abort_i(abort_i),
    .clear_mode_i(clear_mode_i), .origin_x_i(origin_x_i), .origin_y_i(origin_y_i),
    .char_count_i(char_count_i), .bg_colour_i(bg_colour_i), .char_index_o(char_index_o),
    .char_code_i(char_code_i), .glyph_code_o(glyph_code_o), .glyph_x_o(glyph_x_o),
    .glyph_y_o(glyph_y_o), .glyph_enable_i(glyph_enable_i), .glyph_colour_i(glyph_colour_i),
    .plot_o(plot_o), .plot_x_o(plot_x_o), .plot_y_o(plot_y_o), .plot_colour_o(plot_colour_o),
    .plot_ready_i(plot_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected pixels in scan order: chars, then rows, then columns
  task automatic build_model(input int n, input logic [7:0] ox, oy, input logic clr, input logic [5:0] bg);
    exp_q.delete();
    for (int c = 0; c < n; c++)
      for (int y = 0; y < 10; y++)
        for (int x = 0; x < 8; x++)
          if (clr || lut_en(lut_mode, str_mem[c], 8'(x), 8'(y)))
            exp_q.push_back({8'(int'(ox) + c * 8 + x), 8'(int'(oy) + y),
                             clr ? bg : lut_col(str_mem[c], 8'(x), 8'(y))});
  endtask

  // mode: 0 random ready, 1 always ready, 2 five-cycle stall on the first hit
  task automatic run_job(input int n, input logic [7:0] ox, oy, input logic clr,
                         input logic [5:0] bg, input int mode, input int dup_at);
    int edges, stalls, stall_left;
    logic got_done;
    logic [21:0] e;
    build_model(n, ox, oy, clr, bg);
    origin_x_i = ox; origin_y_i = oy; char_count_i = 4'(n); clear_mode_i = clr; bg_colour_i = bg;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    origin_x_i = 8'($urandom); origin_y_i = 8'($urandom); char_count_i = 4'($urandom);
    clear_mode_i = 1'($urandom); bg_colour_i = 6'($urandom);
    edges = 1; stalls = 0; stall_left = (mode == 2) ? 5 : 0; got_done = 1'b0;
    check("busy_after_start", 32'(busy_o), 1);
    while (!got_done && edges < 3000) begin
      start_i = (edges == dup_at);
      if (mode == 0) plot_ready_i = $urandom_range(0, 3) != 0;
      else if (mode == 2 && plot_o && stall_left > 0) begin
        plot_ready_i = 1'b0;
        stall_left--;
      end else plot_ready_i = 1'b1;
      if (done_o) got_done = 1'b1;
      else begin
        if (plot_o) begin
          check("plot_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q[0];
            check("plot_x", 32'(plot_x_o), 32'(e[21:14]));
            check("plot_y", 32'(plot_y_o), 32'(e[13:6]));
            check("plot_colour", 32'(plot_colour_o), 32'(e[5:0]));
            if (plot_ready_i) void'(exp_q.pop_front());
          end
          if (!plot_ready_i) stalls++;
        end
        tick();
        edges++;
      end
    end
    start_i = 1'b0;
    plot_ready_i = 1'b1;
    check("done_cycle", 32'(edges), n == 0 ? 2 : 32'(n * 80 + 3 + stalls));
    check("busy_at_done", 32'(busy_o), 0);
    check("pixels_left", 32'(exp_q.size()), 0);
    tick();
    check("done_one_cycle", 32'(done_o), 0);
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done_o || plot_o) seen++;
      tick();
    end
    check(tag, 32'(seen), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) str_mem[i] = 8'($urandom);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_plot", 32'(plot_o), 0);
    check("rst_plot_x", 32'(plot_x_o), 0);
    check("rst_plot_y", 32'(plot_y_o), 0);
    check("rst_colour", 32'(plot_colour_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_index", 32'(char_index_o), 0);
    check("rst_gxy", 32'({glyph_x_o, glyph_y_o}), 0);

    lut_mode = 1'b1;
    run_job(1, 8'd10, 8'd20, 1'b0, 6'h00, 1, 0);
    run_job(1, 8'd10, 8'd20, 1'b0, 6'h00, 2, 0);
    run_job(2, 8'd0, 8'd0, 1'b1, 6'h15, 1, 0);
    run_job(2, 8'd250, 8'd118, 1'b1, 6'h2a, 1, 0);
    run_job(0, 8'd5, 8'd5, 1'b0, 6'h01, 1, 0);
    lut_mode = 1'b0;
    run_job(2, 8'd30, 8'd40, 1'b0, 6'h00, 0, 37);
    for (int k = 0; k < 6; k++)
      run_job($urandom_range(1, 3), 8'($urandom), 8'($urandom), 1'($urandom), 6'($urandom), 0, 0);
    run_job(1, 8'd252, 8'd250, 1'b0, 6'h00, 2, 0);

    origin_x_i = 8'd0; origin_y_i = 8'd0; char_count_i = 4'd3; clear_mode_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (29) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_plot", 32'(plot_o), 0);
    check("abort_busy", 32'(busy_o), 0);
    watch_no_done("abort_no_done", 40);

    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (29) tick();
    rst_n = 1'b0;
    #1;
    check("areset_plot", 32'(plot_o), 0);
    check("areset_xy", 32'({plot_x_o, plot_y_o, 2'b00, plot_colour_o}), 0);
    check("areset_busy", 32'(busy_o), 0);
    check("areset_idx", 32'({char_index_o, glyph_x_o, glyph_y_o}), 0);
    tick();
    rst_n = 1'b1;
    watch_no_done("areset_no_done", 40);
    clear_mode_i = 1'b0;
    run_job(1, 8'd7, 8'd9, 1'b0, 6'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/char_string_sequencer.md
# char_string_sequencer

Sequences on-screen text rendering. Walks every pixel of a run of character cells, presents cell-relative coordinates and a character code to a shared combinational glyph LUT, and converts LUT hits into single-pixel plot requests toward the framebuffer write arbiter. Sits between game-state logic (score, banners) and the VGA framebuffer port, so glyph modules never compute screen addresses themselves.

## Interface
Parameters:
- CELL_W, 8, glyph cell width in pixels; also the horizontal character pitch
- CELL_H, 10, glyph cell height in pixels
- CNT_W, 4, width of char_count and char_index; maximum 2^CNT_W−1 characters

Ports:
- clock  in  1  system clock; all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  synchronous cancel; wins over every other event
- clear_mode  in  1  1 = erase the cells with bg_colour, 0 = draw glyphs
- origin_x  in  8  screen x of the first cell's top-left pixel
- origin_y  in  8  screen y of the top-left pixel
- char_count  in  CNT_W  number of characters; 0 is legal
- bg_colour  in  6  colour used in clear_mode
- char_index  out  CNT_W  index of the character being scanned
- char_code  in  8  code for char_index, combinational from the caller's string store
- glyph_code  out  8  code forwarded to the glyph LUT
- glyph_x  out  8  cell-relative x, 0..CELL_W−1
- glyph_y  out  8  cell-relative y, 0..CELL_H−1
- glyph_enable  in  1  LUT hit, same cycle
- glyph_colour  in  6  LUT colour, same cycle
- plot  out  1  pixel write request
- plot_x  out  8  screen x
- plot_y  out  8  screen y
- plot_colour  out  6  pixel colour
- plot_ready  in  1  arbiter accepts the pixel when plot && plot_ready
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at completion

## Operation
- States: IDLE, SCAN, DRAIN, FINISH.
- IDLE: when start=1, latch origin_x, origin_y, char_count, clear_mode and bg_colour, and clear counters px, py, ci. Go to SCAN, or go to FINISH if char_count=0. Input changes after the latch have no effect.
- SCAN: glyph_code=char_code, glyph_x=px, glyph_y=py, char_index=ci; all are driven from registered counters. A scan step fires when the output stage is empty or is being accepted in this cycle.
- On a step, load the output stage:
  - plot = clear_mode | glyph_enable
  - plot_x = origin_x + ci·CELL_W + px, mod 256 (wraps; no clipping)
  - plot_y = origin_y + py, mod 256
  - plot_colour = clear_mode ? bg_colour : glyph_colour
- Counter order: px fastest, then py, then ci. When the last pixel is stepped (px=CELL_W−1, py=CELL_H−1, ci=count−1), go to DRAIN.
- Misses (plot=0) still occupy one step and never wait for plot_ready.
- DRAIN: hold until the output stage is empty or accepted, then go to FINISH.
- FINISH: done=1 for one cycle, then IDLE.
- start while busy is ignored.
- abort in any state: next cycle IDLE, plot=0, pending pixel dropped, no done pulse.

## Timing
- Reset values: plot=0, plot_x=plot_y=0, plot_colour=0, busy=0, done=0, char_index=0, glyph_x=glyph_y=0, state IDLE.
- LUT path is combinational in the same cycle; the plot outputs are registered, so latency from step to plot is 1 cycle.
- An asserted plot holds plot_x, plot_y and plot_colour stable until plot_ready; the scan stalls meanwhile.
- Without stalls, start to done takes N·CELL_W·CELL_H + 3 cycles for N≥1. For N=0, done occurs 2 cycles after start.
- busy is high in SCAN, DRAIN and FINISH.

## Structure
- A shared package holds the default CELL_W/CELL_H, the 6-bit colour type, the state enum, and SCREEN_W=160/SCREEN_H=120.
- One sub-module is natural: char_scan_counter (px/py/ci nested counter with step input and last flag).
- The output register stage stays inline.

## Test plan
- Reset mid-SCAN: drop resetn at cycle 30 → all outputs 0 immediately; no done.
- Single char, origin (10,20), LUT hits only at (2,0), plot_ready=1 → one plot at (12,20) with glyph_colour; done at cycle 83.
- clear_mode, count=2, origin (0,0), bg 6'h15 → 160 plots covering x 0..15, y 0..9, all colour 6'h15, in px-py-ci order.
- plot_ready held low for 5 cycles on first hit → plot coordinates stable throughout, no pixel lost or duplicated, done delayed by exactly 5 cycles.
- origin_x=250, count=2 → plot_x wraps through 255 to 0..9.
- count=0 → no plot, done 2 cycles after start; start during busy ignored; abort mid-scan → IDLE, no done.
